// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline sequencer: post-reset clear, stall resolution,
// taken-branch squash with a programmable penalty, and perf counters.

// One source-vs-producer compare. x0 is hardwired zero and never a hazard.
module phc_match #(
  parameter int REG_IDX_W = 5
) (
  input  logic [REG_IDX_W-1:0] rs,
  input  logic                 rs_en,
  input  logic [REG_IDX_W-1:0] dest,
  input  logic                 dest_en,
  output logic                 hit
);
  assign hit = rs_en && (rs != '0) && dest_en && (rs == dest);
endmodule

module pipe_hazard_ctrl #(
  parameter int REG_IDX_W      = 5,
  parameter int INIT_CYCLES    = 4,
  parameter int BRANCH_PENALTY = 1,
  parameter int FORWARDING     = 1,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [REG_IDX_W-1:0] i_fe_rs1,
  input  logic [REG_IDX_W-1:0] i_fe_rs2,
  input  logic                 i_fe_rs1_en,
  input  logic                 i_fe_rs2_en,
  input  logic [REG_IDX_W-1:0] i_id_dest_reg,
  input  logic                 i_id_dest_en,
  input  logic                 i_id_is_load,
  input  logic [REG_IDX_W-1:0] i_ex_dest_reg,
  input  logic [REG_IDX_W-1:0] i_me_dest_reg,
  input  logic                 i_ex_dest_en,
  input  logic                 i_me_dest_en,
  input  logic                 i_branch_taken,
  input  logic                 i_ex_busy,
  input  logic                 i_mem_wait,
  output logic                 o_fe_clr,
  output logic                 o_fe_stall,
  output logic                 o_id_clr,
  output logic                 o_id_stall,
  output logic                 o_ex_clr,
  output logic                 o_ex_stall,
  output logic                 o_me_clr,
  output logic                 o_me_stall,
  output logic                 o_wb_clr,
  output logic                 o_wb_stall,
  output logic                 o_pc_redirect,
  output logic                 o_ready,
  output logic [CNT_W-1:0]     o_stall_cnt,
  output logic [CNT_W-1:0]     o_flush_cnt
);
  localparam int NUM_SRC = 2;   // rs1, rs2
  localparam int NUM_PRD = 3;   // id, ex, me producers
  localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES - 1);
  localparam logic [2:0] PEN_LOAD  = 3'((BRANCH_PENALTY > 0) ? BRANCH_PENALTY - 1 : 0);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_t;

  state_t     state;
  logic [3:0] init_cnt;
  logic [2:0] pen_cnt;

  logic [NUM_SRC-1:0][REG_IDX_W-1:0] src;
  logic [NUM_SRC-1:0]                src_en;
  logic [NUM_PRD-1:0][REG_IDX_W-1:0] prd;
  logic [NUM_PRD-1:0]                prd_en;
  logic [NUM_SRC-1:0][NUM_PRD-1:0]   hit;
  logic [NUM_PRD-1:0]                prd_hit;
  logic                              raw;
  logic                              branch_acc;
  logic                              any_stall;

  assign src    = {i_fe_rs2, i_fe_rs1};
  assign src_en = {i_fe_rs2_en, i_fe_rs1_en};
  assign prd    = {i_me_dest_reg, i_ex_dest_reg, i_id_dest_reg};
  assign prd_en = {i_me_dest_en, i_ex_dest_en, i_id_dest_en};

  // Full source x producer compare matrix.
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    for (genvar p = 0; p < NUM_PRD; p++) begin : g_prd
      phc_match #(.REG_IDX_W(REG_IDX_W)) u_match (
        .rs      (src[s]),
        .rs_en   (src_en[s]),
        .dest    (prd[p]),
        .dest_en (prd_en[p]),
        .hit     (hit[s][p])
      );
    end
  end

  assign prd_hit = hit[0] | hit[1];

  // With forwarding only a load in id cannot be bypassed in time.
  assign raw = (FORWARDING != 0) ? (i_id_is_load && prd_hit[0]) : (|prd_hit);

  // Stage controls decoded from state and live hazard inputs, first match wins.
  always_comb begin
    o_fe_clr = 1'b0; o_fe_stall = 1'b0;
    o_id_clr = 1'b0; o_id_stall = 1'b0;
    o_ex_clr = 1'b0; o_ex_stall = 1'b0;
    o_me_clr = 1'b0; o_me_stall = 1'b0;
    o_wb_clr = 1'b0; o_wb_stall = 1'b0;
    o_pc_redirect = 1'b0;
    branch_acc    = 1'b0;
    if (state == ST_INIT) begin
      o_fe_clr = 1'b1; o_id_clr = 1'b1; o_ex_clr = 1'b1;
      o_me_clr = 1'b1; o_wb_clr = 1'b1;
    end else if (i_mem_wait) begin
      o_fe_stall = 1'b1; o_id_stall = 1'b1; o_ex_stall = 1'b1; o_me_stall = 1'b1;
      o_wb_clr   = 1'b1;
    end else if (i_ex_busy) begin
      o_fe_stall = 1'b1; o_id_stall = 1'b1; o_ex_stall = 1'b1;
      o_me_clr   = 1'b1;
    end else if (state == ST_FLUSH) begin
      o_fe_clr = 1'b1;
    end else if (i_branch_taken) begin
      o_fe_clr      = 1'b1;
      o_id_clr      = 1'b1;
      o_pc_redirect = 1'b1;
      branch_acc    = 1'b1;
    end else if (raw) begin
      o_fe_stall = 1'b1;
      o_id_clr   = 1'b1;
    end
  end

  assign o_ready   = (state != ST_INIT);
  assign any_stall = o_fe_stall | o_id_stall | o_ex_stall | o_me_stall | o_wb_stall;

  // Sequencer state, init/penalty countdowns and wrapping perf counters.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_INIT;
      init_cnt    <= INIT_LOAD;
      pen_cnt     <= '0;
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == '0) state <= ST_RUN;
          else                init_cnt <= init_cnt - 4'd1;
        end
        ST_RUN: begin
          if (branch_acc && (BRANCH_PENALTY > 0)) begin
            state   <= ST_FLUSH;
            pen_cnt <= PEN_LOAD;
          end
        end
        ST_FLUSH: begin
          // Penalty only elapses on cycles where fe is really being cleared.
          if (!i_mem_wait && !i_ex_busy) begin
            if (pen_cnt == '0) state <= ST_RUN;
            else               pen_cnt <= pen_cnt - 3'd1;
          end
        end
        default: state <= ST_INIT;
      endcase
      if (state != ST_INIT && any_stall) o_stall_cnt <= o_stall_cnt + 1'b1;
      if (branch_acc)                    o_flush_cnt <= o_flush_cnt + 1'b1;
    end
  end
endmodule
